// File: rtl/chrisruk_matrix_pkg.sv
// Shared encodings for the LED-matrix message path: character codes,
// ASCII constants and receiver state type.
package chrisruk_matrix_pkg;

  typedef logic [3:0] char_t;

  localparam char_t      CHAR_BLANK  = 4'hF;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_CLEAR = 8'h0C;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  function automatic char_t ascii_to_char(input logic [7:0] b);
    return char_t'(b - ASCII_ZERO);
  endfunction

endpackage

// File: rtl/chrisruk_msg_buffer_if.sv
// Serial input, renderer handshake and status outputs of the message buffer.
interface chrisruk_msg_buffer_if
  import chrisruk_matrix_pkg::*;
#(
  parameter int DEPTH = 16
) ();

  logic                     rx_in;
  logic                     char_next;
  char_t                    char_out;
  logic                     char_valid;
  logic [$clog2(DEPTH):0]   msg_len;
  logic                     overflow;
  logic                     frame_err;

  modport master (
    output rx_in,
    output char_next,
    input  char_out,
    input  char_valid,
    input  msg_len,
    input  overflow,
    input  frame_err
  );

  modport slave (
    input  rx_in,
    input  char_next,
    output char_out,
    output char_valid,
    output msg_len,
    output overflow,
    output frame_err
  );

endinterface

// File: rtl/chrisruk_uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, start-bit validation at half bit,
// mid-bit sampling of data and stop bits.
module chrisruk_uart_rx
  import chrisruk_matrix_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_r;
  logic             rx_s_r;
  logic             rx_prev_r;
  rx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_valid_r;
  logic [7:0]       byte_data_r;
  logic             frame_err_r;

  // Synchronise the line and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_in;
      rx_s_r    <= rx_meta_r;
      rx_prev_r <= rx_s_r;
    end
  end

  // Frame state machine; result strobes are single-cycle registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= RX_IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
          if (rx_prev_r && !rx_s_r) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_END) begin
            cnt_r   <= '0;
            state_r <= rx_s_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_END) begin
            cnt_r   <= '0;
            shift_r <= {rx_s_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_END) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
            if (rx_s_r) begin
              byte_valid_r <= 1'b1;
              byte_data_r  <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= RX_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/chrisruk_msg_buffer.sv
// Digit message store fed by UART; plays the message back one character at a
// time in a loop, advancing on each renderer request.
module chrisruk_msg_buffer
  import chrisruk_matrix_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  chrisruk_msg_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;

  logic             byte_valid_s;
  logic [7:0]       byte_data_s;
  logic             frame_err_s;

  char_t            mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LEN_W-1:0] msg_len_r;
  logic             overflow_r;
  char_t            char_out_r;
  logic             char_valid_r;

  logic             digit_s;
  logic             clear_s;
  logic             append_s;
  logic             advance_s;
  char_t            new_char_s;
  logic [PTR_W-1:0] wr_nxt_s;
  logic [PTR_W-1:0] rd_nxt_s;
  logic [LEN_W-1:0] len_nxt_s;
  logic             ovf_nxt_s;
  char_t            disp_nxt_s;

  chrisruk_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (bus.rx_in),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .frame_err  (frame_err_s)
  );

  // Decode the received byte and compute next pointer/length state.
  always_comb begin
    digit_s    = byte_valid_s && is_digit(byte_data_s);
    clear_s    = byte_valid_s && (byte_data_s == ASCII_CLEAR);
    append_s   = digit_s && (msg_len_r != LEN_W'(DEPTH));
    advance_s  = bus.char_next && (msg_len_r != {LEN_W{1'b0}});
    new_char_s = ascii_to_char(byte_data_s);
    wr_nxt_s   = wr_ptr_r;
    rd_nxt_s   = rd_ptr_r;
    len_nxt_s  = msg_len_r;
    ovf_nxt_s  = overflow_r;
    if (clear_s) begin
      wr_nxt_s  = {PTR_W{1'b0}};
      rd_nxt_s  = {PTR_W{1'b0}};
      len_nxt_s = {LEN_W{1'b0}};
      ovf_nxt_s = 1'b0;
    end else begin
      if (append_s) begin
        wr_nxt_s  = wr_ptr_r + PTR_W'(1);
        len_nxt_s = msg_len_r + LEN_W'(1);
      end else if (digit_s) begin
        ovf_nxt_s = 1'b1;
      end else begin
        ovf_nxt_s = overflow_r;
      end
      // The wrap test deliberately uses the length before any same-cycle append.
      if (advance_s) begin
        if (({1'b0, rd_ptr_r} + LEN_W'(1)) == msg_len_r) begin
          rd_nxt_s = {PTR_W{1'b0}};
        end else begin
          rd_nxt_s = rd_ptr_r + PTR_W'(1);
        end
      end else begin
        rd_nxt_s = rd_ptr_r;
      end
    end
  end

  // Character that will be on display next cycle, including a same-cycle write.
  always_comb begin
    disp_nxt_s = CHAR_BLANK;
    if (len_nxt_s == {LEN_W{1'b0}}) begin
      disp_nxt_s = CHAR_BLANK;
    end else if (append_s && (wr_ptr_r == rd_nxt_s)) begin
      disp_nxt_s = new_char_s;
    end else begin
      disp_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Pointer, length and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      msg_len_r    <= {LEN_W{1'b0}};
      overflow_r   <= 1'b0;
      char_out_r   <= CHAR_BLANK;
      char_valid_r <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_nxt_s;
      rd_ptr_r     <= rd_nxt_s;
      msg_len_r    <= len_nxt_s;
      overflow_r   <= ovf_nxt_s;
      char_out_r   <= disp_nxt_s;
      char_valid_r <= (len_nxt_s != {LEN_W{1'b0}});
    end
  end

  // Message store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= CHAR_BLANK;
      end
    end else if (append_s) begin
      mem_r[wr_ptr_r] <= new_char_s;
    end
  end

  assign bus.char_out   = char_out_r;
  assign bus.char_valid = char_valid_r;
  assign bus.msg_len    = msg_len_r;
  assign bus.overflow   = overflow_r;
  assign bus.frame_err  = frame_err_s;

endmodule

// File: doc/chrisruk_msg_buffer.md
# chrisruk_msg_buffer

Upstream feeder for the LED-matrix scroller. It receives ASCII digits over a UART serial line and stores them as a message of up to `DEPTH` characters. It then plays the message back one character at a time, looping forever. The renderer consumes `char_out` and pulses `char_next` each time a character has fully scrolled off the display.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4, clk cycles per UART bit; must be ≥ 4.
- `DEPTH`, default 16, message capacity in characters; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_in`  in  1  UART 8N1 serial input, idle high; asynchronous to `clk`.
- `char_next`  in  1  one-cycle pulse from the renderer requesting the next character.
- `char_out`  out  4  current character code: 0–9 = digit, 4'hF = blank.
- `char_valid`  out  1  high when the message is non-empty.
- `msg_len`  out  $clog2(DEPTH)+1  number of stored characters.
- `overflow`  out  1  sticky; set when a digit is dropped because the buffer is full.
- `frame_err`  out  1  one-cycle pulse when a received stop bit reads 0.

## Operation
Receiver (`chrisruk_uart_rx`):
- `rx_in` passes through a 2-FF synchroniser; this synchronised signal is called `rx_s` below.
- State machine: IDLE → START → DATA → STOP → IDLE.
- IDLE: a falling edge on `rx_s` enters START.
- START: `rx_s` is re-sampled at `CLKS_PER_BIT/2`. If it is high, the start was false and the FSM returns to IDLE.
- DATA: 8 bits, LSB first, each sampled at mid-bit.
- STOP: mid-bit sample. If 1, `byte_valid` pulses for one cycle with the byte. If 0, `frame_err` pulses and the byte is discarded. Either way, return to IDLE.

Byte decode (on `byte_valid`):
- 0x30–0x39: append value (byte − 0x30) at `wr_ptr`; increment `wr_ptr` and `msg_len`. If `msg_len == DEPTH`, drop the digit and set `overflow`.
- 0x0C (form feed): clear the message. `wr_ptr`, `rd_ptr` and `msg_len` go to 0 and `overflow` clears.
- All other bytes: ignored.

Playback:
- `char_out = mem[rd_ptr]` when `msg_len > 0`, otherwise 4'hF.
- `char_valid = (msg_len != 0)`.
- On `char_next` with `msg_len > 0`: `rd_ptr` increments and wraps to 0 when `rd_ptr + 1 == msg_len`, comparing against the pre-update `msg_len`.
- `char_next` while `msg_len == 0` is ignored.

Boundary rules:
- Append and `char_next` in the same cycle: both take effect. The wrap test uses the old length.
- Clear and `char_next` in the same cycle: clear wins, so `rd_ptr = 0`.
- Writing into the slot currently being displayed cannot happen. Writes only go to index `msg_len`, which is greater than `rd_ptr`.
- Reset mid-frame: the receiver returns to IDLE and the partial byte is lost.

## Timing
Reset values:
- `char_out` = 4'hF, `char_valid` = 0, `msg_len` = 0, `overflow` = 0, `frame_err` = 0.
- All pointers = 0 and the receiver is in IDLE.
- Memory contents are don't-care.

Latency and cycle rules:
- Start edge on `rx_in` to `byte_valid`: 2 synchroniser cycles + 9.5 × `CLKS_PER_BIT` cycles (±1).
- `byte_valid` to `msg_len`/`char_out` update: 1 cycle, registered.
- `char_next` at cycle n: new `char_out` is visible at n+1.
- `frame_err`: exactly one cycle wide, asserted in the same cycle `byte_valid` would have been.
- Back-to-back frames with a single stop bit are received without loss. The receiver re-arms in IDLE right after the stop-bit mid-sample.

## Structure
Shared package `chrisruk_matrix_pkg` holds:
- `CHAR_BLANK` = 4'hF
- `ASCII_ZERO` = 8'h30
- `ASCII_NINE` = 8'h39
- `ASCII_CLEAR` = 8'h0C
- a 4-bit `char_t` typedef, so the renderer uses the same encoding.

Sub-module: `chrisruk_uart_rx`, parameterised by `CLKS_PER_BIT`. Outputs are `byte_valid`, `byte_data[7:0]` and `frame_err`.

The message store is a flat register array, `DEPTH` × 4 bits, with no RAM macro.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Reset with `reset` = 0 mid-frame: all outputs at their reset values, `char_out` = 4'hF. After release, the next full frame is received correctly.
- Send "1","2","3": `msg_len` = 3 and `char_out` = 1. `char_next` pulses then give 2, 3, 1, 2 (wrap).
- Send 16 digits then "7": `msg_len` = 16 and `overflow` = 1; the 17th digit does not appear in playback. Send 0x0C: `msg_len` = 0, `overflow` = 0, `char_valid` = 0, `char_out` = 4'hF.
- Frame with stop bit = 0: `frame_err` pulses once and `msg_len` is unchanged. A glitch low for 1 cycle on idle `rx_in`: no byte is received.
- With `msg_len` = 2 and `rd_ptr` = 1, `char_next` lands in the same cycle as the append of "5": `rd_ptr` wraps to 0 and `msg_len` = 3.
- Bytes 'A' (0x41) and 0x0D are ignored. `char_next` with an empty buffer changes nothing.
